avalon_bram_burst: RTL and testbench
====================================

// Module: avalon_bram_burst
//
// PURPOSE
// Parametrised Avalon-MM agent wrapping an on-chip synchronous block RAM.
// Successor of the fixed 32-bit burst BRAM agent, adding:
//   - configurable data width and depth,
//   - explicit IDLE/WRITE/READ burst FSM with write-beat stalls,
//   - byte-lane writes,
//   - address wrap-around.
// Sits behind the Avalon interconnect as a slave memory for test masters and
// the memory-controller datapath.
//
// PARAMETERS
// DATA_W        32  data bus width in bits, multiple of 8 (NB_BYTES = DATA_W/8, power of 2)
// RAM_ADD_W      8  log2 of the number of DATA_W words in the RAM
// BURSTCOUNT_W   4  burstcount width; maximum burst length = 2**(BURSTCOUNT_W-1)
//
// PORTS
// clk            in   1              system clock, all logic on rising edge
// reset          in   1              synchronous, active-high reset
// address        in   32             byte address; word index = (address >> log2(NB_BYTES)) mod 2**RAM_ADD_W
// read           in   1              read command
// write          in   1              write command / write beat
// burstcount     in   BURSTCOUNT_W   beats in burst, sampled on first accepted beat
// byteenable     in   NB_BYTES       byte lanes written on each write beat
// writedata      in   DATA_W         write beat data
// waitrequest    out  1              agent stall; command/beat accepted when asserted request && !waitrequest
// readdata       out  DATA_W         read beat data
// readdatavalid  out  1              readdata valid this cycle
//
// BEHAVIOUR
// - One clock (clk). Reset is synchronous and active-high.
// - Reset (any cycle, including mid-burst):
//     - FSM -> IDLE; waitrequest=0, readdatavalid=0, readdata=0; beat counters = 0.
//     - RAM contents are NOT cleared.
// - FSM states: IDLE, WRITE, READ.
// - burstcount rules:
//     - Value 0 is treated as 1.
//     - Values above 2**(BURSTCOUNT_W-1) are clamped to that maximum.
// - IDLE (waitrequest=0):
//     - write: beat 0 written at base word.
//         - If burst length = 1, stay in IDLE.
//         - Otherwise latch base + length, beat counter=1, go to WRITE.
//     - read: latch base + length, issue RAM read of beat 0, go to READ.
//     - read && write in the same cycle is a protocol violation:
//         - The write is performed and the read is dropped.
//         - The bench flags it by assertion.
// - WRITE (waitrequest=0):
//     - Each cycle with write=1 writes beat k to word (base+k) mod depth, then k++.
//     - write=0 is a stall: no state change and no RAM write.
//     - address and burstcount are ignored after beat 0.
//     - After the last beat, return to IDLE.
//     - read asserted in WRITE is ignored.
// - READ:
//     - RAM is synchronous with 1-cycle latency.
//     - readdatavalid=1 on exactly N consecutive cycles.
//         - The first is the cycle after acceptance.
//         - Beat k carries word (base+k) mod depth.
//     - waitrequest=1 from the cycle after acceptance through the cycle carrying the last readdatavalid.
//     - A new command can be accepted on the following cycle (IDLE), so read-to-read turnaround = N+1 cycles.
// - Writes: byte lane i is written iff byteenable[i]=1; other lanes keep their old value.
// - Address arithmetic:
//     - Word index and beat offset are added in RAM_ADD_W bits.
//     - Wrap from word 2**RAM_ADD_W-1 to word 0 is silent.
//     - Low log2(NB_BYTES) address bits are ignored.
// - Beat counters are BURSTCOUNT_W bits wide; they never exceed the clamped length.
// - readdata holds its last value when readdatavalid=0.
//
// STRUCTURE
// - Package avalon_bram_pkg:
//     - typedef enum logic [1:0] {IDLE, WRITE, READ} bram_state_t
//     - function burst_len(burstcount, BURSTCOUNT_W): 0->1 mapping and clamp
// - Sub-module bram_be: simple dual-port RAM, DATA_W x 2**RAM_ADD_W.
//     - Write port with per-byte enable.
//     - Registered 1-cycle read port.
// - Top level: FSM, base/length/beat registers, address adder, handshake outputs.
//
// TESTING
// 1. Single write 0xDEADBEEF @0x40, be=0xF; single read @0x40
//      -> readdatavalid 1 cycle after acceptance, readdata=0xDEADBEEF.
// 2. Burst write 8 beats 0x0..0x7 @0x100 (bc=8); burst read bc=8 @0x100
//      -> 8 consecutive valids, data 0..7, waitrequest high through the last valid.
// 3. Write burst bc=4 with write dropped for 2 cycles after beat 1
//      -> all 4 beats land at words 0x40..0x43; readback matches.
// 4. Burst write bc=4 at word 254 (depth 256)
//      -> words 254, 255, 0, 1 written; read bc=4 @ byte 0x3F8 returns them in order.
// 5. Word=0x11223344, then write 0xAABBCCDD with be=0b0101
//      -> readback 0x11BB33DD.
// 6. Reset pulsed during beat 3 of an 8-beat read
//      -> next cycle readdatavalid=0, waitrequest=0; prior RAM contents still readable.

Source files
------------

// File: rtl/avalon_bram_pkg.sv
// Shared types and helpers for the Avalon-MM burst BRAM agent.
package avalon_bram_pkg;

    typedef enum logic [1:0] {IDLE, WRITE, READ} bram_state_t;

    // A burstcount of 0 means one beat; anything above 2**(width-1) is clamped.
    function automatic int unsigned burst_len(input int unsigned burstcount,
                                              input int unsigned BURSTCOUNT_W);
        int unsigned maxLen;
        maxLen = 32'd1 << (BURSTCOUNT_W - 32'd1);
        if (burstcount == 32'd0)
            return 32'd1;
        else if (burstcount > maxLen)
            return maxLen;
        else
            return burstcount;
    endfunction

endpackage

// File: rtl/bram_be.sv
// Simple dual-port block RAM with per-byte write enables and a registered read port.
module bram_be #(
    parameter int DATA_W    = 32,
    parameter int RAM_ADD_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_we,
    input  logic [DATA_W/8-1:0]   i_be,
    input  logic [RAM_ADD_W-1:0]  i_wAddr,
    input  logic [DATA_W-1:0]     i_wData,
    input  logic                  i_re,
    input  logic [RAM_ADD_W-1:0]  i_rAddr,
    output logic [DATA_W-1:0]     o_rData
);

    localparam int NB_BYTES = DATA_W / 8;
    localparam int DEPTH    = 2 ** RAM_ADD_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB_BYTES; i++) begin
            if (i_we && i_be[i])
                r_mem[i_wAddr][i*8 +: 8] <= i_wData[i*8 +: 8];
        end
    end

    // The output register only moves on a read, so data holds between beats.
    always_ff @(posedge clk) begin
        if (reset)
            o_rData <= '0;
        else if (i_re)
            o_rData <= r_mem[i_rAddr];
    end

endmodule

// File: rtl/avalon_bram_burst.sv
// Avalon-MM burst agent in front of a byte-enabled block RAM: IDLE/WRITE/READ FSM,
// burst length clamping and wrap-around word addressing.
module avalon_bram_burst
    import avalon_bram_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int RAM_ADD_W    = 8,
    parameter int BURSTCOUNT_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             address,
    input  logic                    read,
    input  logic                    write,
    input  logic [BURSTCOUNT_W-1:0] burstcount,
    input  logic [DATA_W/8-1:0]     byteenable,
    input  logic [DATA_W-1:0]       writedata,
    output logic                    waitrequest,
    output logic [DATA_W-1:0]       readdata,
    output logic                    readdatavalid
);

    localparam int NB_BYTES   = DATA_W / 8;
    localparam int BYTE_SHIFT = $clog2(NB_BYTES);
    localparam logic [31:0] USED_MASK = ((32'd1 << RAM_ADD_W) - 32'd1) << BYTE_SHIFT;

    bram_state_t              r_state, w_nextState;
    logic [RAM_ADD_W-1:0]     r_baseWord, w_nextBase;
    logic [BURSTCOUNT_W-1:0]  r_len, w_nextLen;
    logic [BURSTCOUNT_W-1:0]  r_beat, w_nextBeat;
    logic [BURSTCOUNT_W-1:0]  w_len;
    logic [RAM_ADD_W-1:0]     w_wordIdx;
    logic [RAM_ADD_W-1:0]     w_ramAddr;
    logic                     w_we;
    logic                     w_re;
    logic                     w_unusedAddr;

    assign w_wordIdx    = address[BYTE_SHIFT +: RAM_ADD_W];
    assign w_unusedAddr = ^(address & ~USED_MASK);
    assign w_len        = BURSTCOUNT_W'(burst_len(32'(burstcount), BURSTCOUNT_W));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_baseWord <= '0;
            r_len      <= '0;
            r_beat     <= '0;
        end else begin
            r_state    <= w_nextState;
            r_baseWord <= w_nextBase;
            r_len      <= w_nextLen;
            r_beat     <= w_nextBeat;
        end
    end

    // Beat 0 is serviced straight from the incoming address; later beats use base + beat.
    always_comb begin
        w_nextState = r_state;
        w_nextBase  = r_baseWord;
        w_nextLen   = r_len;
        w_nextBeat  = r_beat;
        w_we        = 1'b0;
        w_re        = 1'b0;
        w_ramAddr   = w_wordIdx;
        case (r_state)
            IDLE: begin
                if (write) begin
                    w_we = 1'b1;
                    if (w_len != BURSTCOUNT_W'(1)) begin
                        w_nextBase  = w_wordIdx;
                        w_nextLen   = w_len;
                        w_nextBeat  = BURSTCOUNT_W'(1);
                        w_nextState = WRITE;
                    end
                end else if (read) begin
                    w_re        = 1'b1;
                    w_nextBase  = w_wordIdx;
                    w_nextLen   = w_len;
                    w_nextBeat  = BURSTCOUNT_W'(1);
                    w_nextState = READ;
                end
            end
            WRITE: begin
                w_ramAddr = r_baseWord + RAM_ADD_W'(r_beat);
                if (write) begin
                    w_we = 1'b1;
                    if (r_beat == r_len - BURSTCOUNT_W'(1)) begin
                        w_nextBeat  = '0;
                        w_nextState = IDLE;
                    end else begin
                        w_nextBeat = r_beat + BURSTCOUNT_W'(1);
                    end
                end
            end
            READ: begin
                // Each READ cycle presents the previous beat; leave once the last is on the bus.
                w_ramAddr = r_baseWord + RAM_ADD_W'(r_beat);
                if (r_beat == r_len) begin
                    w_nextBeat  = '0;
                    w_nextState = IDLE;
                end else begin
                    w_re       = 1'b1;
                    w_nextBeat = r_beat + BURSTCOUNT_W'(1);
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign waitrequest   = (r_state == READ);
    assign readdatavalid = (r_state == READ);

    bram_be #(
        .DATA_W    (DATA_W),
        .RAM_ADD_W (RAM_ADD_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_we),
        .i_be    (byteenable),
        .i_wAddr (w_ramAddr),
        .i_wData (writedata),
        .i_re    (w_re),
        .i_rAddr (w_ramAddr),
        .o_rData (readdata)
    );

endmodule

// File: tb/tb_avalon_bram_burst.sv
// Directed bench for avalon_bram_burst: single and burst transfers, stalls, wrap,
// byte lanes, burstcount clamping and reset in the middle of a read burst.
module tb_avalon_bram_burst;

    logic        clk;
    logic        reset;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  burstcount;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] wrData  [8];
    logic [31:0] expBeats[8];

    avalon_bram_burst #(
        .DATA_W       (32),
        .RAM_ADD_W    (8),
        .BURSTCOUNT_W (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .read          (read),
        .write         (write),
        .burstcount    (burstcount),
        .byteenable    (byteenable),
        .writedata     (writedata),
        .waitrequest   (waitrequest),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The bench never drives read and write together; this catches it if it does.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(read && write)) else begin
                miscompares++;
                $error("[TB] FAIL protocol: read and write asserted together");
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; drives n beats from wrData, optionally stalling 2 cycles after beat stallAfter.
    task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] bc,
                                 input logic [3:0] be, input int n, input int stallAfter);
        for (int k = 0; k < n; k++) begin
            write      = 1'b1;
            writedata  = wrData[k];
            byteenable = be;
            address    = (k == 0) ? addr : 32'hFFFF_FFFC;
            burstcount = (k == 0) ? bc : 4'd1;
            checkOutput("write waitrequest", 32'(waitrequest), 32'd0);
            @(negedge clk);
            if (k == stallAfter) begin
                write     = 1'b0;
                writedata = 32'hBAD0_BAD0;
                repeat (2) @(negedge clk);
            end
        end
        write = 1'b0;
    endtask

    // Called at a negedge; issues a read and checks n beats against expBeats, then the return to idle.
    task automatic readBurst(input logic [31:0] addr, input logic [3:0] bc, input int n);
        address    = addr;
        burstcount = bc;
        read       = 1'b1;
        checkOutput("read accept waitrequest", 32'(waitrequest), 32'd0);
        @(negedge clk);
        read = 1'b0;
        for (int k = 0; k < n; k++) begin
            checkOutput("read valid", 32'(readdatavalid), 32'd1);
            checkOutput("read waitrequest", 32'(waitrequest), 32'd1);
            checkOutput("read data", readdata, expBeats[k]);
            @(negedge clk);
        end
        checkOutput("read end valid", 32'(readdatavalid), 32'd0);
        checkOutput("read end waitrequest", 32'(waitrequest), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        address    = '0;
        read       = 1'b0;
        write      = 1'b0;
        burstcount = 4'd1;
        byteenable = 4'hF;
        writedata  = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset waitrequest", 32'(waitrequest), 32'd0);
        checkOutput("reset valid", 32'(readdatavalid), 32'd0);
        checkOutput("reset readdata", readdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] single write/read");
        wrData[0] = 32'hDEAD_BEEF;
        applyStimulus(32'h40, 4'd1, 4'hF, 1, -1);
        expBeats[0] = 32'hDEAD_BEEF;
        readBurst(32'h40, 4'd1, 1);

        $display("[TB] 8-beat burst");
        wrData = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7};
        applyStimulus(32'h100, 4'd8, 4'hF, 8, -1);
        expBeats = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7};
        readBurst(32'h100, 4'd8, 8);

        $display("[TB] stalled 4-beat write");
        wrData = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h0, 32'h0, 32'h0, 32'h0};
        applyStimulus(32'h100, 4'd4, 4'hF, 4, 1);
        expBeats = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h4, 32'h5, 32'h6, 32'h7};
        readBurst(32'h100, 4'd4, 4);

        $display("[TB] burstcount clamp 15 -> 8");
        readBurst(32'h100, 4'd15, 8);

        $display("[TB] wrap at top of RAM");
        wrData = '{32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'h0, 32'h0, 32'h0, 32'h0};
        applyStimulus(32'h3F8, 4'd4, 4'hF, 4, -1);
        expBeats = '{32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'h0, 32'h0, 32'h0, 32'h0};
        readBurst(32'h3F8, 4'd4, 4);
        expBeats = '{32'hC2, 32'hC3, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        readBurst(32'h0, 4'd2, 2);

        $display("[TB] byte-lane write");
        wrData[0] = 32'h1122_3344;
        applyStimulus(32'h80, 4'd1, 4'hF, 1, -1);
        wrData[0] = 32'hAABB_CCDD;
        applyStimulus(32'h80, 4'd1, 4'b0101, 1, -1);
        expBeats[0] = 32'h11BB_33DD;
        readBurst(32'h80, 4'd1, 1);

        $display("[TB] burstcount 0 and unaligned address");
        readBurst(32'h80, 4'd0, 1);
        readBurst(32'h83, 4'd1, 1);

        $display("[TB] reset during read burst");
        address    = 32'h100;
        burstcount = 4'd8;
        read       = 1'b1;
        @(negedge clk);
        read = 1'b0;
        expBeats = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h4, 32'h5, 32'h6, 32'h7};
        for (int k = 0; k < 4; k++) begin
            checkOutput("pre-reset valid", 32'(readdatavalid), 32'd1);
            checkOutput("pre-reset data", readdata, expBeats[k]);
            if (k < 3) @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid-burst reset valid", 32'(readdatavalid), 32'd0);
        checkOutput("mid-burst reset waitrequest", 32'(waitrequest), 32'd0);
        checkOutput("mid-burst reset readdata", readdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        expBeats[0] = 32'hDEAD_BEEF;
        readBurst(32'h40, 4'd1, 1);
        expBeats = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h4, 32'h5, 32'h6, 32'h7};
        readBurst(32'h100, 4'd8, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
